// File: rtl/pbch_qpsk_demap_if.sv
// Stream bundle for the PBCH QPSK demapper: equalized REs in, LLR pairs out.
// slave is the demapper side, master the producer/consumer side.
interface pbch_qpsk_demap_if #(
    parameter int IN_DW  = 32,
    parameter int LLR_DW = 8
);
    logic [IN_DW-1:0]    s_axis_in_tdata;
    logic [1:0]          s_axis_in_tuser;
    logic                s_axis_in_tvalid;
    logic [2*LLR_DW-1:0] m_axis_out_tdata;
    logic                m_axis_out_tlast;
    logic                m_axis_out_tvalid;
    logic                m_axis_out_tready;

    modport slave (
        input  s_axis_in_tdata,
        input  s_axis_in_tuser,
        input  s_axis_in_tvalid,
        output m_axis_out_tdata,
        output m_axis_out_tlast,
        output m_axis_out_tvalid,
        input  m_axis_out_tready
    );

    modport master (
        output s_axis_in_tdata,
        output s_axis_in_tuser,
        output s_axis_in_tvalid,
        input  m_axis_out_tdata,
        input  m_axis_out_tlast,
        input  m_axis_out_tvalid,
        output m_axis_out_tready
    );
endinterface

// File: rtl/pbch_qpsk_demap.sv
// Soft QPSK demapper + PBCH frame packer with FWFT output FIFO.
// Optional PBCH_DEMAP_DROP_CNT_EN adds a saturating drop counter output.
module pbch_qpsk_demap #(
    parameter int IN_DW     = 32,
    parameter int LLR_DW    = 8,
    parameter int LLR_SHIFT = 7,
    parameter int N_DATA_RE = 432,
    parameter int FIFO_LEN  = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    pbch_qpsk_demap_if.slave  axis,
    output logic              overflow_o,
    output logic              frame_err_o
`ifdef PBCH_DEMAP_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt_o
`endif
);
    localparam int HW = IN_DW / 2;
    localparam int EW = 2 * LLR_DW + 1;
    localparam int AW = $clog2(FIFO_LEN);
    localparam int CW = $clog2(N_DATA_RE + 1);
    localparam int LMAX = (1 << (LLR_DW - 1)) - 1;
    localparam logic signed [HW-1:0] SMAX = HW'(LMAX);
    localparam logic signed [HW-1:0] SMIN = -SMAX;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_DATA_RE - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_LEN);

    typedef enum logic {IDLE, COLLECT} state_t;

    // Symmetric clamp: the most negative code is never emitted.
    function automatic logic [LLR_DW-1:0] scale(input logic signed [HW-1:0] c);
        logic signed [HW-1:0] s;
        s = c >>> LLR_SHIFT;
        if (s > SMAX) return SMAX[LLR_DW-1:0];
        if (s < SMIN) return SMIN[LLR_DW-1:0];
        return s[LLR_DW-1:0];
    endfunction

    logic              s1_valid_d, s1_valid_q;
    logic [1:0]        s1_user_d, s1_user_q;
    logic [LLR_DW-1:0] s1_re_d, s1_re_q;
    logic [LLR_DW-1:0] s1_im_d, s1_im_q;

    always_comb begin
        s1_valid_d = axis.s_axis_in_tvalid;
        s1_user_d  = axis.s_axis_in_tuser;
        s1_re_d    = scale(axis.s_axis_in_tdata[HW-1:0]);
        s1_im_d    = scale(axis.s_axis_in_tdata[IN_DW-1:HW]);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s1_user_q  <= '0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_user_q  <= s1_user_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
        end
    end

    state_t        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [CW-1:0] base;
    logic          active, wr, wr_last;
    logic          ferr_d, ferr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ferr_d  = ferr_q;
        base    = cnt_q;
        active  = 1'b0;
        wr      = 1'b0;
        wr_last = 1'b0;
        if (s1_valid_q) begin
            if (s1_user_q[1]) begin
                base    = '0;
                active  = 1'b1;
                state_d = COLLECT;
                cnt_d   = '0;
                if (state_q == COLLECT) ferr_d = 1'b1;
            end else if (state_q == COLLECT) begin
                active = 1'b1;
            end
            if (active && !s1_user_q[0]) begin
                wr      = 1'b1;
                wr_last = (base == LAST_CNT);
                cnt_d   = wr_last ? '0 : base + 1'b1;
                state_d = wr_last ? IDLE : COLLECT;
            end
        end
    end

    logic [EW-1:0] mem_q [FIFO_LEN];
    logic [AW-1:0] wp_d, wp_q, rp_d, rp_q;
    logic [AW:0]   fcnt_d, fcnt_q;
    logic          full, rd, wr_ok;
    logic          ovf_d, ovf_q;
    logic [EW-1:0] rd_word;

    // A read in the same cycle frees the slot, so a write on full still lands.
    always_comb begin
        full   = (fcnt_q == FULL_CNT);
        rd     = axis.m_axis_out_tvalid && axis.m_axis_out_tready;
        wr_ok  = wr && (!full || rd);
        wp_d   = wr_ok ? wp_q + 1'b1 : wp_q;
        rp_d   = rd ? rp_q + 1'b1 : rp_q;
        ovf_d  = ovf_q | (wr && !wr_ok);
        fcnt_d = fcnt_q;
        unique case ({wr_ok, rd})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wp_q] <= {wr_last, s1_im_q, s1_re_q};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            fcnt_q  <= fcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        rd_word                = mem_q[rp_q];
        axis.m_axis_out_tvalid = (fcnt_q != '0);
        axis.m_axis_out_tdata  = axis.m_axis_out_tvalid ?
                                 rd_word[2*LLR_DW-1:0] : '0;
        axis.m_axis_out_tlast  = axis.m_axis_out_tvalid & rd_word[EW-1];
        overflow_o             = ovf_q;
        frame_err_o            = ferr_q;
    end

`ifdef PBCH_DEMAP_DROP_CNT_EN
    logic [15:0] drop_d, drop_q;

    always_comb begin
        drop_d = drop_q;
        if (wr && !wr_ok && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) drop_q <= '0;
        else         drop_q <= drop_d;
    end

    assign drop_cnt_o = drop_q;
`endif
endmodule

// File: tb/tb_pbch_qpsk_demap.sv
// Bench for pbch_qpsk_demap: directed frames plus random REs checked
// against a frame-level LLR model and expected-beat queue.
module tb_pbch_qpsk_demap;
    logic clk = 1'b0;
    logic reset_i;
    logic overflow, ferr;
`ifdef PBCH_DEMAP_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    pbch_qpsk_demap_if #(.IN_DW(32), .LLR_DW(8)) axis ();

    pbch_qpsk_demap dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .axis        (axis.slave),
        .overflow_o  (overflow),
        .frame_err_o (ferr)
`ifdef PBCH_DEMAP_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [16:0] expq [$];
    logic [15:0] got [$];
    int beat_cnt, last_cnt, last_idx;

    bit m_in_frame;
    int m_cnt;
    bit m_bp;
    int m_drops;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Floor division by 2^7 then symmetric clamp to +-127.
    function automatic int llr(input int c);
        int q;
        q = (c >= 0) ? c / 128 : -((-c + 127) / 128);
        if (q > 127) q = 127;
        if (q < -127) q = -127;
        return q;
    endfunction

    task automatic model_re(input int re, input int im, input logic [1:0] u);
        logic last;
        logic [7:0] lr, li;
        if (u[1]) begin
            m_in_frame = 1'b1;
            m_cnt = 0;
        end
        if (!m_in_frame || u[0]) return;
        last = (m_cnt == 431);
        m_cnt++;
        if (last) m_in_frame = 1'b0;
        lr = 8'(llr(re));
        li = 8'(llr(im));
        if (m_bp && expq.size() >= 64) m_drops++;
        else expq.push_back({last, li, lr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_re(input int re, input int im, input logic [1:0] u);
        model_re(re, im, u);
        axis.s_axis_in_tdata  = {16'(im), 16'(re)};
        axis.s_axis_in_tuser  = u;
        axis.s_axis_in_tvalid = 1'b1;
        step();
        axis.s_axis_in_tvalid = 1'b0;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic finish_frame(input bit dmrs_rand);
        logic [1:0] u;
        while (m_in_frame) begin
            u = {1'b0, dmrs_rand && ($urandom_range(0, 3) == 0)};
            send_re(rnd16(), rnd16(), u);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        repeat (4) step();
        while ((expq.size() != 0 || axis.m_axis_out_tvalid) && n < 3000) begin
            step();
            n++;
        end
        check("drain_done", 32'(n < 3000), 32'd1);
    endtask

    task automatic clr_stats();
        beat_cnt = 0;
        last_cnt = 0;
        last_idx = 0;
        got.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        expq.delete();
        m_in_frame = 1'b0;
        m_cnt = 0;
        m_drops = 0;
        step();
        reset_i = 1'b0;
    endtask

    logic [16:0] mon_e;
    always @(negedge clk) begin
        if (!reset_i && axis.m_axis_out_tvalid && axis.m_axis_out_tready) begin
            beat_cnt++;
            got.push_back(axis.m_axis_out_tdata);
            if (axis.m_axis_out_tlast) begin
                last_cnt++;
                last_idx = beat_cnt;
            end
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extra_beat observed=%0h expected=none",
                       axis.m_axis_out_tdata);
            end else begin
                mon_e = expq.pop_front();
                check("beat_data", 32'(axis.m_axis_out_tdata), 32'(mon_e[15:0]));
                check("beat_last", 32'(axis.m_axis_out_tlast), 32'(mon_e[16]));
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        axis.s_axis_in_tdata  = '0;
        axis.s_axis_in_tuser  = '0;
        axis.s_axis_in_tvalid = 1'b0;
        axis.m_axis_out_tready = 1'b1;
        m_bp = 1'b0;
        m_drops = 0;
        m_in_frame = 1'b0;
        m_cnt = 0;
        clr_stats();
        repeat (3) step();
        check("rst_tvalid", 32'(axis.m_axis_out_tvalid), 32'd0);
        check("rst_tdata", 32'(axis.m_axis_out_tdata), 32'd0);
        check("rst_tlast", 32'(axis.m_axis_out_tlast), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
`ifdef PBCH_DEMAP_DROP_CNT_EN
        check("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        reset_i = 1'b0;
        step();

        // Directed frame with latency probe on the first data RE
        send_re(16384, -16384, 2'b11);
        send_re(16384, -16384, 2'b00);
        check("lat_c1", 32'(axis.m_axis_out_tvalid), 32'd0);
        step();
        check("lat_c2", 32'(axis.m_axis_out_tvalid), 32'd1);
        for (int i = 1; i < 576; i++)
            send_re(16384, -16384, (i % 4 == 3) ? 2'b01 : 2'b00);
        wait_drain();
        check("d_beats", 32'(beat_cnt), 32'd432);
        check("d_lastcnt", 32'(last_cnt), 32'd1);
        check("d_lastidx", 32'(last_idx), 32'd432);
        check("d_word0", 32'(got[0]), 32'h817F);
        check("d_ovf", 32'(overflow), 32'd0);
        check("d_ferr", 32'(ferr), 32'd0);

        // Saturation and floor-rounding corners, then random fill
        clr_stats();
        send_re(0, 0, 2'b11);
        send_re(-32768, 32767, 2'b00);
        send_re(127, -128, 2'b00);
        send_re(-129, 129, 2'b00);
        send_re(16256, -16256, 2'b00);
        finish_frame(1'b1);
        wait_drain();
        check("s_w0", 32'(got[0]), 32'h7F81);
        check("s_w1", 32'(got[1]), 32'hFF00);
        check("s_w2", 32'(got[2]), 32'h01FE);
        check("s_w3", 32'(got[3]), 32'h817F);
        check("s_beats", 32'(beat_cnt), 32'd432);
        check("s_lastidx", 32'(last_idx), 32'd432);

        // Backpressure for a whole frame
        clr_stats();
        axis.m_axis_out_tready = 1'b0;
        m_bp = 1'b1;
        send_re(0, 0, 2'b11);
        finish_frame(1'b0);
        repeat (5) step();
        check("bp_tvalid", 32'(axis.m_axis_out_tvalid), 32'd1);
        check("bp_ovf", 32'(overflow), 32'd1);
        check("bp_ferr", 32'(ferr), 32'd0);
`ifdef PBCH_DEMAP_DROP_CNT_EN
        check("bp_drop", 32'(drop_cnt), 32'(m_drops));
`endif
        axis.m_axis_out_tready = 1'b1;
        m_bp = 1'b0;
        wait_drain();
        check("bp_beats", 32'(beat_cnt), 32'd64);
        check("bp_lastcnt", 32'(last_cnt), 32'd0);
        do_reset();
        check("bp_rst_ovf", 32'(overflow), 32'd0);

        // Early restart
        clr_stats();
        send_re(0, 0, 2'b11);
        for (int i = 0; i < 100; i++) send_re(rnd16(), rnd16(), 2'b00);
        send_re(0, 0, 2'b11);
        finish_frame(1'b0);
        wait_drain();
        check("er_ferr", 32'(ferr), 32'd1);
        check("er_beats", 32'(beat_cnt), 32'd532);
        check("er_lastcnt", 32'(last_cnt), 32'd1);
        check("er_lastidx", 32'(last_idx), 32'd532);
        do_reset();

        // Reset in the middle of a frame
        clr_stats();
        send_re(0, 0, 2'b11);
        for (int i = 0; i < 200; i++)
            send_re(rnd16(), rnd16(), {1'b0, ($urandom_range(0, 3) == 0)});
        axis.m_axis_out_tready = 1'b0;
        do_reset();
        check("mr_tvalid", 32'(axis.m_axis_out_tvalid), 32'd0);
        check("mr_tdata", 32'(axis.m_axis_out_tdata), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        check("mr_ferr", 32'(ferr), 32'd0);
        repeat (3) step();
        check("mr_flushed", 32'(axis.m_axis_out_tvalid), 32'd0);
        axis.m_axis_out_tready = 1'b1;
        clr_stats();
        send_re(rnd16(), rnd16(), 2'b10);
        finish_frame(1'b1);
        wait_drain();
        check("mr_beats", 32'(beat_cnt), 32'd432);
        check("mr_lastidx", 32'(last_idx), 32'd432);
        check("mr_ferr2", 32'(ferr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pbch_qpsk_demap.md
# pbch_qpsk_demap

Soft QPSK demapper and PBCH frame packer downstream of the channel estimator. Consumes the equalized resource-element stream (`m_axis_cest_out_*`), discards DMRS REs, and converts each data RE into two saturated signed LLRs. Buffers them in an output FIFO under a proper AXI-Stream `tready` handshake. Marks the last RE of each PBCH (432 data REs = 864 LLRs) with `tlast` for the PBCH decoder.

## Interface
- `IN_DW`, 32: input RE width; real part in `[IN_DW/2-1:0]`, imag in `[IN_DW-1:IN_DW/2]`, both signed.
- `LLR_DW`, 8: signed LLR width.
- `LLR_SHIFT`, 7: arithmetic right shift applied before saturation.
- `N_DATA_RE`, 432: data REs per PBCH.
- `FIFO_LEN`, 64: output FIFO depth, power of two, ≥ 4.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `s_axis_in_tdata`  in  IN_DW  equalized RE.
- `s_axis_in_tuser`  in  2  bit0 = DMRS RE (discard); bit1 = first RE of an SSB.
- `s_axis_in_tvalid`  in  1  RE valid; no backpressure, input always accepted.
- `m_axis_out_tdata`  out  2*LLR_DW  {LLR_imag, LLR_real}.
- `m_axis_out_tlast`  out  1  last data RE of a PBCH.
- `m_axis_out_tvalid`  out  1  FIFO not empty.
- `m_axis_out_tready`  in  1  downstream accept.
- `overflow_o`  out  1  sticky; an RE was dropped on a full FIFO.
- `frame_err_o`  out  1  sticky; SSB start arrived before N_DATA_RE REs were collected.

## Operation
- Stage 1, registered: for each component, compute `c >>> LLR_SHIFT` and saturate symmetrically to [-(2^(LLR_DW-1)-1), +(2^(LLR_DW-1)-1)]. The most negative code is never produced. Positive LLR means bit 0.
- Stage 2, collector FSM:
  - IDLE: ignore all REs until a valid RE with `tuser[1]=1`. Then go to COLLECT with `re_cnt=0`. That RE is processed as in COLLECT.
  - COLLECT: each valid RE with `tuser[0]=0` writes one FIFO entry and increments `re_cnt`. DMRS REs write nothing. The entry with `re_cnt==N_DATA_RE-1` carries `tlast=1`, and the FSM returns to IDLE.
  - A start RE (`tuser[1]=1`) seen in COLLECT sets `frame_err_o` and restarts `re_cnt` at 0. That RE is treated as the first of a new frame. Already-written entries of the aborted frame remain in the FIFO with no `tlast`.
  - An RE with both `tuser` bits set is a start marker and is discarded as DMRS.
- FIFO: synchronous, first-word fall-through.
  - Write while full: entry dropped, `overflow_o` set, `re_cnt` still advances so frame alignment is kept.
  - Simultaneous read and write while full: the read is honoured first and the write succeeds.
- `overflow_o` and `frame_err_o` clear only on reset.

## Timing
- Latency from input RE to `m_axis_out_tvalid` with an empty FIFO: 3 cycles. Cycle 1 is scaling, cycle 2 is the FSM/FIFO write, cycle 3 is output valid.
- Throughput: one RE per cycle in, one beat per cycle out while `tready=1`.
- A beat transfers when `tvalid && tready`. `tdata` and `tlast` are held stable while `tvalid && !tready`.
- Reset values: FSM=IDLE, `re_cnt=0`, FIFO empty, `m_axis_out_tvalid=0`, `m_axis_out_tdata=0`, `m_axis_out_tlast=0`, `overflow_o=0`, `frame_err_o=0`.
- Reset mid-frame flushes the FIFO and pipeline within 1 cycle. Stage-1 contents are discarded.

## Configuration
- `PBCH_DEMAP_DROP_CNT_EN`: when defined, adds output `drop_cnt_o` [15:0]. It counts every FIFO write dropped on overflow, saturates at 16'hFFFF, and resets to 0.
- Without the macro the port and counter do not exist; `overflow_o` alone reports drops.

## Test plan
- Directed frame: start RE, then 576 REs with 144 flagged DMRS, `tready=1`, RE = (re=+16384, im=-16384), LLR_DW=8, shift 7. Expect 432 beats of {-127, +127}; `tlast` only on beat 432; no flags set.
- Saturation/rounding: re=-32768 -> -127; re=+127 -> 0; re=-129 -> -2; re=+16256 -> +127.
- Backpressure: `tready=0` for the whole frame with FIFO_LEN=64. Expect 64 entries held and `overflow_o=1`. After releasing `tready`, 64 beats drain in order and no `tlast` appears.
- Early restart: start RE, 100 data REs, a second start RE, then 432 data REs. Expect `frame_err_o=1` and 532 beats total, with `tlast` only on beat 532.
- Reset mid-frame: assert `reset_i` for 1 cycle after 200 REs. Expect `tvalid=0` on the next cycle, all flags 0, and a clean frame afterwards.
- With `PBCH_DEMAP_DROP_CNT_EN`: repeat the backpressure case. Expect `drop_cnt_o = 432-64 = 368`.
